// File: rtl/adrv9001_axil_pkg.sv
// Shared types and constants for the ADRV9001 control-block AXI4-Lite master.
// Word indices address 32-bit registers; byte address is index * 4.
package adrv9001_axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5,
    DRAIN   = 3'd6
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_GPIO     = 1;
  localparam int unsigned REG_GPIO_T   = 2;
  localparam int unsigned REG_TX1_SRC  = 3;
  localparam int unsigned REG_TX2_SRC  = 4;
  localparam int unsigned REG_TX1_DATA = 5;
  localparam int unsigned REG_TX2_DATA = 6;
  localparam int unsigned REG_RX1_DATA = 7;
  localparam int unsigned REG_RX2_DATA = 8;
  localparam int unsigned REG_TX1_TRIG = 9;
  localparam int unsigned REG_TX2_TRIG = 10;
  localparam int unsigned REG_RX1_TRIG = 11;
  localparam int unsigned REG_RX2_TRIG = 12;
  localparam int unsigned REG_ID       = 15;

endpackage

// File: rtl/adrv9001_axil_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready command stream.
// All bus and handshake outputs are registered; response phases are timeout-bounded.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered, each dropped on its own ready
// WR_RESP | bready high, waiting for B or timeout
// RD_REQ  | AR offered until arready
// RD_RESP | rready high, waiting for R or timeout
// RSP     | rsp_valid high until rsp_ready
// DRAIN   | swallow the one late beat of a timed-out transaction
module adrv9001_axil_master
  import adrv9001_axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [15:0]           TMO_LIM    = 16'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  axil_state_e           state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  drain_q, drain_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  resp_beat;

  assign resp_beat = (bready_q && m_axi_bvalid) || (rready_q && m_axi_rvalid);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      drain_q       <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      drain_q       <= drain_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    drain_d       = drain_q;
    tmo_cnt_d     = tmo_cnt_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          write_d     = cmd_write;
          addr_d      = cmd_addr & ALIGN_MASK;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave once both are gone.
        awvalid_d = awvalid_q && !m_axi_awready;
        wvalid_d  = wvalid_q && !m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d  = 1'b1;
          tmo_cnt_d = '0;
          state_d   = WR_RESP;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_cnt_d = '0;
          state_d   = RD_RESP;
        end
      end
      WR_RESP, RD_RESP: begin
        if (resp_beat) begin
          bready_d      = 1'b0;
          rready_d      = 1'b0;
          rsp_resp_d    = write_q ? m_axi_bresp : m_axi_rresp;
          rsp_rdata_d   = write_q ? 32'h0 : m_axi_rdata;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RSP;
        end else if (tmo_cnt_q == TMO_LIM) begin
          bready_d      = 1'b0;
          rready_d      = 1'b0;
          rsp_resp_d    = RESP_SLVERR;
          rsp_rdata_d   = 32'h0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          drain_d       = 1'b1;
          state_d       = RSP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (drain_q) begin
            bready_d = write_q;
            rready_d = !write_q;
            state_d  = DRAIN;
          end else begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      DRAIN: begin
        if (resp_beat) begin
          bready_d    = 1'b0;
          rready_d    = 1'b0;
          drain_d     = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign busy          = (state_q != IDLE);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_adrv9001_axil_master.sv
// Bench for adrv9001_axil_master: control-block slave with programmable ready delays,
// directed vector table, timing corner sequences and a randomized run against a word-level model.
module tb_adrv9001_axil_master;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [6:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  adrv9001_axil_master #(.ADDR_WIDTH(7), .TIMEOUT_CYCLES(8)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // Slave: words 0..14 RW, 15 is a read-only ID, words 16..31 answer SLVERR.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic        b_en = 1'b1;
  int          late_b_req = 0, late_b_ack, b_cnt, aw_hs_cnt;
  int          aw_cnt, w_cnt, ar_cnt;
  logic [31:0] mem [32];
  logic        got_aw, got_w, sl_aw_hs, sl_w_hs;
  logic [6:0]  sl_aw_addr, sl_a, last_awaddr, last_araddr;
  logic [31:0] sl_wd, sl_d;
  logic [3:0]  sl_ws, sl_s, last_wstrb;

  always @(posedge clk) begin
    if (!aresetn) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      b_cnt <= 0; aw_hs_cnt <= 0; late_b_ack <= late_b_req;
      for (int i = 0; i < 32; i++) mem[i] <= (i == 15) ? 32'h12345678 : 32'h0;
    end else begin
      sl_aw_hs = awvalid && awready;
      sl_w_hs  = wvalid && wready;
      if (sl_aw_hs) begin
        awready <= 1'b0; aw_cnt <= 0; sl_aw_addr <= awaddr; aw_hs_cnt <= aw_hs_cnt + 1;
      end else if (awvalid && !awready) begin
        if (aw_cnt >= aw_dly) awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end else aw_cnt <= 0;
      if (sl_w_hs) begin
        wready <= 1'b0; w_cnt <= 0; sl_wd <= wdata; sl_ws <= wstrb;
      end else if (wvalid && !wready) begin
        if (w_cnt >= w_dly) wready <= 1'b1; else w_cnt <= w_cnt + 1;
      end else w_cnt <= 0;
      sl_a = sl_aw_hs ? awaddr : sl_aw_addr;
      sl_d = sl_w_hs ? wdata : sl_wd;
      sl_s = sl_w_hs ? wstrb : sl_ws;
      if ((got_aw || sl_aw_hs) && (got_w || sl_w_hs)) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        last_awaddr <= sl_a; last_wstrb <= sl_s;
        if (sl_a[6:2] < 5'd15)
          for (int i = 0; i < 4; i++)
            if (sl_s[i]) mem[sl_a[6:2]][8*i +: 8] <= sl_d[8*i +: 8];
        if (b_en) begin bvalid <= 1'b1; bresp <= sl_a[6] ? 2'b10 : 2'b00; end
      end else begin
        if (sl_aw_hs) got_aw <= 1'b1;
        if (sl_w_hs) got_w <= 1'b1;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_cnt <= b_cnt + 1;
      end else if (!bvalid && late_b_req != late_b_ack) begin
        bvalid <= 1'b1; bresp <= 2'b00; late_b_ack <= late_b_req;
      end
      if (arvalid && arready) begin
        arready <= 1'b0; ar_cnt <= 0; last_araddr <= araddr;
        rvalid <= 1'b1;
        rdata  <= araddr[6] ? 32'h0 : mem[araddr[6:2]];
        rresp  <= araddr[6] ? 2'b10 : 2'b00;
      end else if (arvalid && !arready) begin
        if (ar_cnt >= ar_dly) arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
      end else ar_cnt <= 0;
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  int wv_alone = 0;
  always @(negedge clk) if (wvalid && !awvalid) wv_alone <= wv_alone + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model of the control block at word level.
  logic [31:0] model_mem [32];
  task automatic model_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] rs);
    int w;
    w = int'(a) / 4;
    rs = (w >= 16) ? 2'b10 : 2'b00;
    if (w < 16 && w != int'(adrv9001_axil_pkg::REG_ID))
      for (int i = 0; i < 4; i++) if (s[i]) model_mem[w][8*i +: 8] = d[8*i +: 8];
  endtask
  task automatic model_read(input logic [6:0] a, output logic [31:0] rd, output logic [1:0] rs);
    int w;
    w = int'(a) / 4;
    rd = (w >= 16) ? 32'h0 : model_mem[w];
    rs = (w >= 16) ? 2'b10 : 2'b00;
  endtask

  // One command; lat counts cycles from the handshake cycle N to the first rsp_valid cycle.
  task automatic do_txn(input logic w, input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output logic [31:0] rd, output logic [1:0] rs,
                        output logic to, output int lat, output logic v1);
    int g;
    logic stable;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    v1 = w ? (awvalid && wvalid) : arvalid;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs || rsp_timeout !== to ||
            cmd_ready !== 1'b0 || awvalid || wvalid || arvalid || bready || rready) stable = 1'b0;
      end
      chk("hold_stable", stable, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] er;
    logic [1:0]  ers;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] rd, erd;
    logic [1:0]  rs, ers;
    logic        to, v1;
    int          lat, b0, aw0, wv0, mx;
    logic        w;
    logic [6:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    vecs[0] = '{1'b1, 7'h00, 32'h0000010F, 4'hF, 32'h0,        2'b00};
    vecs[1] = '{1'b0, 7'h00, 32'h0,        4'h0, 32'h0000010F, 2'b00};
    vecs[2] = '{1'b0, 7'h3C, 32'h0,        4'h0, 32'h12345678, 2'b00};
    vecs[3] = '{1'b1, 7'h05, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00};
    vecs[4] = '{1'b0, 7'h04, 32'h0,        4'h0, 32'h00BB00DD, 2'b00};
    vecs[5] = '{1'b1, 7'h3C, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
    vecs[6] = '{1'b0, 7'h3E, 32'h0,        4'h0, 32'h12345678, 2'b00};
    vecs[7] = '{1'b1, 7'h40, 32'hDEADBEEF, 4'hF, 32'h0,        2'b10};
    vecs[8] = '{1'b0, 7'h7E, 32'h0,        4'h0, 32'h0,        2'b10};
    for (int i = 0; i < 32; i++) model_mem[i] = (i == 15) ? 32'h12345678 : 32'h0;

    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, busy}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_axi_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_axi_payload", {awaddr, araddr, wdata, wstrb, awprot, arprot}, 0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_release", cmd_ready, 1);

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, 0, rd, rs, to, lat, v1);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].er);
      chk($sformatf("vec%0d_resp", i), rs, vecs[i].ers);
      chk($sformatf("vec%0d_timeout", i), to, 0);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_valid_n1", i), v1, 1);
      if (vecs[i].w) begin
        chk($sformatf("vec%0d_awaddr", i), last_awaddr, {vecs[i].a[6:2], 2'b00});
        chk($sformatf("vec%0d_wstrb", i), last_wstrb, vecs[i].s);
        model_write(vecs[i].a, vecs[i].d, vecs[i].s, ers);
      end else begin
        chk($sformatf("vec%0d_araddr", i), last_araddr, {vecs[i].a[6:2], 2'b00});
      end
    end

    // awready three cycles ahead of wready
    aw_dly = 0; w_dly = 3;
    b0 = b_cnt; aw0 = aw_hs_cnt; wv0 = wv_alone;
    do_txn(1'b1, 7'h08, 32'h00000055, 4'hF, 0, rd, rs, to, lat, v1);
    model_write(7'h08, 32'h00000055, 4'hF, ers);
    repeat (3) @(negedge clk);
    chk("skew_latency", lat, 7);
    chk("skew_resp", rs, 0);
    chk("skew_w_alone", wv_alone - wv0, 3);
    chk("skew_aw_hs", aw_hs_cnt - aw0, 1);
    chk("skew_b_beats", b_cnt - b0, 1);
    chk("skew_no_extra_rsp", rsp_valid, 0);
    w_dly = 0;

    // B never arrives, then shows up late and is drained
    b_en = 1'b0;
    b0 = b_cnt;
    do_txn(1'b1, 7'h0C, 32'h0000A5A5, 4'hF, 0, rd, rs, to, lat, v1);
    model_write(7'h0C, 32'h0000A5A5, 4'hF, ers);
    chk("tmo_latency", lat, 12);
    chk("tmo_resp", rs, 2'b10);
    chk("tmo_flag", to, 1);
    chk("tmo_rdata", rd, 0);
    b_en = 1'b1;
    @(negedge clk);
    chk("drain_cmd_ready_low", cmd_ready, 0);
    chk("drain_bready", {bready, busy}, 2'b11);
    late_b_req = late_b_req + 1;
    @(negedge clk);
    chk("drain_late_b_seen", {bvalid, cmd_ready}, 2'b10);
    @(negedge clk);
    chk("drain_done_cmd_ready", {cmd_ready, bready, busy}, 3'b100);
    chk("drain_b_beats", b_cnt - b0, 1);

    // response held off for five cycles
    do_txn(1'b0, 7'h00, 32'h0, 4'h0, 5, rd, rs, to, lat, v1);
    chk("hold_rdata", rd, 32'h0000010F);
    chk("hold_resp", rs, 0);

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      a = 7'($urandom); d = $urandom; s = 4'($urandom);
      mx = (aw_dly > w_dly) ? aw_dly : w_dly;
      if (w) begin
        model_write(a, d, s, ers);
        erd = 32'h0;
      end else begin
        model_read(a, erd, ers);
      end
      do_txn(w, a, d, s, 0, rd, rs, to, lat, v1);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_resp", i), rs, ers);
      chk($sformatf("rnd%0d_timeout", i), to, 0);
      chk($sformatf("rnd%0d_latency", i), lat, w ? 4 + mx : 4 + ar_dly);
    end

    // reset while arvalid is pending
    ar_dly = 10;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h08;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_arvalid_before", arvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_busy_ready", {busy, cmd_ready, rready}, 3'b000);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd_ready", {cmd_ready, busy}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adrv9001_axil_master.md
# adrv9001_axil_master

AXI4-Lite initiator that turns a simple valid/ready command stream into single-beat AXI4-Lite read and write transactions. It is the bus master for the ADRV9001 control register block: address map words 0..31, byte address [6:2]. It lets a fabric sequencer (enable/trigger scripts, DGPIO updates) program the radio without a processor. One transaction is outstanding at a time, and every response phase is bounded by a timeout.

## Interface
- ADDR_WIDTH, 7: AXI byte-address width.
- TIMEOUT_CYCLES, 255: maximum wait for B/R response, counted in clocks (1..65535).
- m_axi_aclk  in  1: the only clock.
- m_axi_aresetn  in  1: reset, asynchronous, active-low.
- cmd_valid  in  1 / cmd_ready  out  1: command handshake.
- cmd_write  in  1: 1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH: byte address; bits [1:0] are forced to 0 on the bus.
- cmd_wdata  in  32 / cmd_wstrb  in  4: write payload.
- rsp_valid  out  1 / rsp_ready  in  1: response handshake.
- rsp_rdata  out  32: read data; 0 for writes.
- rsp_resp  out  2: BRESP/RRESP as received; 2'b10 on timeout.
- rsp_timeout  out  1: response was generated by the timeout.
- busy  out  1: state is not IDLE.
- m_axi_aw{addr,prot,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{resp,valid,ready}, m_axi_ar{addr,prot,valid,ready}, m_axi_r{data,resp,valid,ready}: standard AXI4-Lite master signals. addr is ADDR_WIDTH, data is 32, strb is 4, prot is 3 and tied to 3'b000.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch all cmd_* fields.
  - Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ
  - awvalid and wvalid assert together in the same cycle.
  - Each deasserts independently on its own ready handshake.
  - Leave for WR_RESP once both handshakes have occurred, including the case where both happen in the same cycle.
  - No timeout in this state: valid is never withdrawn before its ready.
- RD_REQ: arvalid held until arready, then go to RD_RESP.
- WR_RESP / RD_RESP
  - bready/rready = 1 while in the state.
  - On the beat, capture resp (and rdata for reads), then go to RSP.
  - The timeout counter runs in these states only. It is cleared on entry.
  - When the counter reaches TIMEOUT_CYCLES with no beat: go to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, and set a pending-drain flag.
- RSP
  - rsp_valid=1, outputs stable until rsp_ready.
  - On handshake, go to DRAIN if drain is pending, else IDLE.
- DRAIN
  - Keep bready/rready (whichever matches the latched command) = 1.
  - Discard exactly one late beat, then go to IDLE.
  - cmd_ready stays 0; there is no exit without the beat or reset.
- Reset asserted in any state: immediately IDLE, all valids/readies 0, captured data cleared, drain flag cleared. An in-flight transaction is abandoned.
- A back-to-back command is accepted in the first IDLE cycle after the RSP handshake.

## Timing
- Reset values
  - cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, busy=0.
  - All m_axi valid/ready=0, addr=0, data=0, strb=0.
- cmd_ready is registered and rises on the first clock after reset release.
- All AXI outputs are registered: valids assert the cycle after the command handshake (N).
- Against a slave with one-cycle awready/wready and next-cycle bvalid:
  - AW/W valid at N+1.
  - Ready at N+2.
  - B beat at N+3.
  - rsp_valid at N+4.
  - Read path timing is the same: AR valid N+1, arready N+2, R beat N+3, rsp_valid N+4.
- cmd_ready is low from N+1 until the cycle after the RSP handshake.
- Timeout: rsp_valid asserts exactly TIMEOUT_CYCLES+1 clocks after the response-phase state is entered.
- The timeout counter is 16-bit and never wraps, since it is compared before increment.

## Structure
- Shared package adrv9001_axil_pkg holds:
  - the FSM state enum;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the register word-index constants of the control block (CTRL=0, GPIO=1, GPIO_T=2, TX1_SRC=3, TX2_SRC=4, TX1_DATA=5, TX2_DATA=6, RX1_DATA=7, RX2_DATA=8, TX1_TRIG=9, TX2_TRIG=10, RX1_TRIG=11, RX2_TRIG=12, ID=15).
- Single module; no sub-module is warranted.

## Test plan
- Write 0x0000010F to byte address 0x00 against the control register block:
  - AW/W valid together at N+1;
  - awaddr=0, wstrb=4'hF;
  - rsp_valid at N+4 with rsp_resp=0;
  - readback of word 0 returns 0x10F.
- Read byte address 0x3C → rsp_rdata=0x12345678, rsp_resp=0, rsp_valid at N+4.
- Slave model asserts awready 3 cycles before wready → wvalid stays high alone until wready, exactly one B accepted, single response.
- Slave never returns B, TIMEOUT_CYCLES=8 → rsp_valid 9 clocks after WR_RESP entry, rsp_resp=2'b10, rsp_timeout=1. A late bvalid then drains, and cmd_ready returns high the following cycle.
- rsp_ready held low 5 cycles → rsp_* stable throughout, cmd_ready=0, no new AXI activity.
- Assert m_axi_aresetn low while arvalid is high → arvalid=0 the same cycle (asynchronously), busy=0, and cmd_ready=1 one clock after release.
